// File: rtl/dp_res_serializer.sv
// dp_res_serializer
// Transmit-side engine for the dot-product accelerator result path.
// Takes one result vector (DOTP_WIDTH words of WORD_SIZE bits). It can
// add a partial-sum slot to the vector first. The vector is then either
// parked in a slot or serialized onto an OUT_WIDTH valid/ready stream,
// word 0 first, in the LSBs.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             synchronous clear/abort (zeroes slots and shifter)
//   res_valid_i/o_ready input vector handshake (res_ready_o)
//   res_data_i          result vector, word k at [k*WORD_SIZE +: WORD_SIZE]
//   res_add_i           add slot[buf_idx_i] to the incoming vector
//   res_to_buffer_i     write the sum to slot[buf_idx_i] instead of sending
//   buf_idx_i           slot index (out-of-range reads 0, writes dropped)
//   out_valid_o/ready_i output stream handshake
//   out_data_o          output beat, out_strb_o all ones while valid
//   done_o              one-cycle pulse after the last beat handshake
//   buffered_o          one-cycle pulse after a vector is written to a slot
//   beat_cnt_o          beats sent for the current vector

module dp_res_serializer #(
  parameter int DOTP_WIDTH = 4,
  parameter int WORD_SIZE  = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int BUF_SIZE   = 2,
  parameter int IDX_W      = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1,
  localparam int NBEATS    = DOTP_WIDTH * WORD_SIZE / OUT_WIDTH,
  localparam int CNT_W     = $clog2(NBEATS) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic                            res_valid_i,
  output logic                            res_ready_o,
  input  logic [DOTP_WIDTH*WORD_SIZE-1:0] res_data_i,
  input  logic                            res_add_i,
  input  logic                            res_to_buffer_i,
  input  logic [IDX_W-1:0]                buf_idx_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [OUT_WIDTH-1:0]            out_data_o,
  output logic [OUT_WIDTH/8-1:0]          out_strb_o,
  output logic                            done_o,
  output logic                            buffered_o,
  output logic [CNT_W-1:0]                beat_cnt_o
);

  localparam int DW = DOTP_WIDTH * WORD_SIZE;

  if ((OUT_WIDTH % WORD_SIZE) != 0) begin : g_chkWord
    $error("OUT_WIDTH must be a multiple of WORD_SIZE");
  end
  if ((DW % OUT_WIDTH) != 0) begin : g_chkBeat
    $error("DOTP_WIDTH*WORD_SIZE must be a multiple of OUT_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [DW-1:0]    r_slots [BUF_SIZE];
  logic [DW-1:0]    r_shift;
  logic [CNT_W-1:0] r_beatCnt;
  logic             r_done;
  logic             r_buffered;

  logic             w_idxInRange;
  logic [DW-1:0]    w_slotRead;
  logic [DW-1:0]    w_sum;
  logic             w_accept;
  logic             w_handshake;
  logic             w_lastBeat;

  // Ready is held low for as long as reset is asserted, even though the
  // state register already reads IDLE during reset.
  assign res_ready_o = (r_state == IDLE) && !rst_i;
  assign out_valid_o = (r_state == SEND);
  // The shifter is always zero outside SEND, so the beat needs no gating.
  assign out_data_o  = r_shift[OUT_WIDTH-1:0];
  assign out_strb_o  = {(OUT_WIDTH/8){out_valid_o}};
  assign done_o      = r_done;
  assign buffered_o  = r_buffered;
  assign beat_cnt_o  = r_beatCnt;

  // Clear wins over both an accept and a beat handshake.
  assign w_accept    = res_valid_i && res_ready_o && !clear_i;
  assign w_handshake = (r_state == SEND) && out_ready_i && !clear_i;
  assign w_lastBeat  = w_handshake && (r_beatCnt == CNT_W'(NBEATS - 1));

  // Per-word wrapping add of the selected slot. An out-of-range index
  // behaves like an empty slot.
  always_comb begin
    w_idxInRange = (int'(buf_idx_i) < BUF_SIZE);
    w_slotRead   = '0;
    w_sum        = '0;
    if (w_idxInRange) begin
      w_slotRead = r_slots[buf_idx_i];
    end
    for (int k = 0; k < DOTP_WIDTH; k++) begin
      w_sum[k*WORD_SIZE +: WORD_SIZE] = res_data_i[k*WORD_SIZE +: WORD_SIZE]
        + (res_add_i ? w_slotRead[k*WORD_SIZE +: WORD_SIZE] : '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept && !res_to_buffer_i) w_nextState = SEND;
      SEND: if (w_lastBeat) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (clear_i) begin
      w_nextState = IDLE;
    end
  end

  // Slots, shifter, beat counter and the two status pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        r_slots[i] <= '0;
      end
      r_shift    <= '0;
      r_beatCnt  <= '0;
      r_done     <= 1'b0;
      r_buffered <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_buffered <= 1'b0;
      if (clear_i) begin
        for (int i = 0; i < BUF_SIZE; i++) begin
          r_slots[i] <= '0;
        end
        r_shift   <= '0;
        r_beatCnt <= '0;
      end else if (w_accept) begin
        if (res_to_buffer_i) begin
          if (w_idxInRange) begin
            r_slots[buf_idx_i] <= w_sum;
          end
          r_buffered <= 1'b1;
        end else begin
          r_shift   <= w_sum;
          r_beatCnt <= '0;
          // A partial sum that has been added into a sent vector is spent.
          if (res_add_i && w_idxInRange) begin
            r_slots[buf_idx_i] <= '0;
          end
        end
      end else if (w_handshake) begin
        r_shift   <= r_shift >> OUT_WIDTH;
        r_beatCnt <= r_beatCnt + 1'b1;
        if (w_lastBeat) begin
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dp_res_serializer.sv
// tb_dp_res_serializer
// Self-checking bench for dp_res_serializer. A word-level model of the
// partial-sum slots predicts every beat; directed cases cover the
// documented scenarios and a randomized loop mixes the rest. The DUT is
// built with three slots so that index 3 is genuinely out of range.

module tb_dp_res_serializer;

  localparam int DOTP = 4;
  localparam int WS   = 16;
  localparam int OW   = 32;
  localparam int BUF  = 3;
  localparam int IDXW = 2;
  localparam int DW   = DOTP * WS;
  localparam int NB   = DW / OW;
  localparam int CW   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clear = 1'b0;
  logic            resValid = 1'b0;
  logic            resReady;
  logic [DW-1:0]   resData = '0;
  logic            resAdd = 1'b0;
  logic            resToBuffer = 1'b0;
  logic [IDXW-1:0] bufIdx = '0;
  logic            outValid;
  logic            outReady = 1'b0;
  logic [OW-1:0]   outData;
  logic [OW/8-1:0] outStrb;
  logic            done;
  logic            buffered;
  logic [CW-1:0]   beatCnt;

  int checks = 0;
  int errors = 0;

  // Reference slots, one entry per word; index 3 is a spare never written.
  logic [WS-1:0] modelSlot [4][DOTP];

  dp_res_serializer #(
    .DOTP_WIDTH(DOTP),
    .WORD_SIZE (WS),
    .OUT_WIDTH (OW),
    .BUF_SIZE  (BUF)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .res_valid_i    (resValid),
    .res_ready_o    (resReady),
    .res_data_i     (resData),
    .res_add_i      (resAdd),
    .res_to_buffer_i(resToBuffer),
    .buf_idx_i      (bufIdx),
    .out_valid_o    (outValid),
    .out_ready_i    (outReady),
    .out_data_o     (outData),
    .out_strb_o     (outStrb),
    .done_o         (done),
    .buffered_o     (buffered),
    .beat_cnt_o     (beatCnt)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] modelSum(input logic [DW-1:0] data,
                                             input logic add, input int idx);
    logic [DW-1:0] result;
    logic [WS-1:0] w;
    result = '0;
    for (int k = 0; k < DOTP; k++) begin
      w = data[k*WS +: WS];
      if (add && idx < BUF) w = w + modelSlot[idx][k];
      result[k*WS +: WS] = w;
    end
    return result;
  endfunction

  task automatic clearModel();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < DOTP; k++)
        modelSlot[s][k] = '0;
  endtask

  // Drives one vector from a negedge and checks its whole life cycle,
  // returning on the negedge where the DUT is idle and ready again.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic add,
                               input logic toBuf, input int idx,
                               input int firstStall, input bit randStall);
    logic [DW-1:0] sum;
    logic [OW-1:0] beats [NB];
    int            stall;
    checkOutput("ready_before_accept", resReady, 1);
    sum         = modelSum(data, add, idx);
    resValid    = 1'b1;
    resData     = data;
    resAdd      = add;
    resToBuffer = toBuf;
    bufIdx      = IDXW'(idx);
    @(negedge clk);
    resValid    = 1'b0;
    resAdd      = 1'b0;
    resToBuffer = 1'b0;
    resData     = {$urandom, $urandom};
    if (toBuf) begin
      if (idx < BUF)
        for (int k = 0; k < DOTP; k++) modelSlot[idx][k] = sum[k*WS +: WS];
      checkOutput("buffered_pulse", buffered, 1);
      checkOutput("no_valid_when_buffering", outValid, 0);
      @(negedge clk);
      checkOutput("buffered_single", buffered, 0);
    end else begin
      if (add && idx < BUF)
        for (int k = 0; k < DOTP; k++) modelSlot[idx][k] = '0;
      for (int b = 0; b < NB; b++) beats[b] = sum[b*OW +: OW];
      checkOutput("ready_low_in_send", resReady, 0);
      for (int b = 0; b < NB; b++) begin
        stall = (b == 0) ? firstStall : (randStall ? int'($urandom_range(0, 2)) : 0);
        repeat (stall) begin
          outReady = 1'b0;
          checkOutput("valid_held", outValid, 1);
          checkOutput("data_held", outData, beats[b]);
          checkOutput("cnt_held", beatCnt, b);
          @(negedge clk);
        end
        outReady = 1'b1;
        checkOutput("beat_valid", outValid, 1);
        checkOutput("beat_data", outData, beats[b]);
        checkOutput("beat_strb", outStrb, 4'hF);
        checkOutput("beat_cnt", beatCnt, b);
        checkOutput("no_early_done", done, 0);
        @(negedge clk);
        outReady = 1'b0;
      end
      checkOutput("valid_drop", outValid, 0);
      checkOutput("done_pulse", done, 1);
      checkOutput("final_cnt", beatCnt, NB);
      checkOutput("ready_after_send", resReady, 1);
      @(negedge clk);
      checkOutput("done_single", done, 0);
    end
  endtask

  initial begin
    clearModel();

    // Reset values while reset is still asserted.
    #12;
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_ready", resReady, 0);
    checkOutput("rst_data", outData, 0);
    checkOutput("rst_strb", outStrb, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_buffered", buffered, 0);
    checkOutput("rst_cnt", beatCnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] plain transmit and backpressure");
    applyStimulus(64'h0004_0003_0002_0001, 1'b0, 1'b0, 0, 0, 1'b0);
    applyStimulus(64'h0004_0003_0002_0001, 1'b0, 1'b0, 0, 3, 1'b0);

    $display("[TB] accumulate then send");
    applyStimulus(64'h0001_0001_0001_0001, 1'b0, 1'b1, 1, 0, 1'b0);
    applyStimulus(64'h0004_0003_0002_FFFF, 1'b1, 1'b0, 1, 0, 1'b0);
    applyStimulus(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1, 0, 1'b0);

    $display("[TB] out-of-range index");
    applyStimulus(64'h0007_0007_0007_0007, 1'b0, 1'b1, 0, 0, 1'b0);
    applyStimulus(64'h1111_2222_3333_4444, 1'b0, 1'b1, 3, 0, 1'b0);
    applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b0, 3, 0, 1'b0);
    applyStimulus(64'h0000_0000_0000_0001, 1'b1, 1'b0, 0, 0, 1'b0);

    $display("[TB] clear mid-send");
    applyStimulus(64'h0009_0009_0009_0009, 1'b0, 1'b1, 2, 0, 1'b0);
    resValid = 1'b1;
    resData  = 64'h0008_0007_0006_0005;
    @(negedge clk);
    resValid = 1'b0;
    checkOutput("clr_valid_before", outValid, 1);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("clr_cnt_after_beat0", beatCnt, 1);
    outReady = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    clearModel();
    checkOutput("clr_valid", outValid, 0);
    checkOutput("clr_done", done, 0);
    checkOutput("clr_ready", resReady, 1);
    checkOutput("clr_cnt", beatCnt, 0);
    @(negedge clk);
    checkOutput("clr_no_late_done", done, 0);
    applyStimulus(64'h0101_0202_0303_0404, 1'b1, 1'b0, 2, 0, 1'b0);

    $display("[TB] async reset mid-send");
    applyStimulus(64'h0005_0005_0005_0005, 1'b0, 1'b1, 0, 0, 1'b0);
    resValid = 1'b1;
    resData  = 64'h0040_0030_0020_0010;
    @(negedge clk);
    resValid = 1'b0;
    checkOutput("ars_valid_before", outValid, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("ars_valid_now", outValid, 0);
    checkOutput("ars_ready_now", resReady, 0);
    checkOutput("ars_cnt_now", beatCnt, 0);
    clearModel();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(64'h0004_0003_0002_0001, 1'b1, 1'b0, 0, 0, 1'b0);

    $display("[TB] randomized vectors");
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        outReady = 1'($urandom);
        @(negedge clk);
        checkOutput("idle_no_valid", outValid, 0);
        checkOutput("idle_no_done", done, 0);
      end
      outReady = 1'b0;
      applyStimulus({$urandom, $urandom}, 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
